// File: rtl/vdp_pkg.sv
// Shared constants for the VDP CPU-side VRAM write port:
// register offsets, STATUS bit positions and drain FSM states.
package vdp_pkg;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_DATA    = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wr_state_e;

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO holding queued {addr,data} VRAM writes.
// Head word is visible on dout whenever the FIFO is non-empty.
module vram_wr_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vram_writer.sv
// CPU register port queuing VRAM writes, drained in arbiter-granted slots.
// Define VRAM_WRITER_IRQ_EN to add the irq output.
module vram_writer
  import vdp_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_cs,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_rs,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic              vram_gnt,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [DATA_W-1:0] vram_wdata,
`ifdef VRAM_WRITER_IRQ_EN
  output logic              irq,
`endif
  output logic              vram_we
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0]        ptr;
  logic                     overflow;
  wr_state_e                state;
  logic [ADDR_W+DATA_W-1:0] head;
  logic                     full;
  logic                     empty;
  logic [CW-1:0]            count;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     push;
  logic                     pop;
  logic                     ovf_set;
  logic                     stat_rd;
  logic                     busy;
  logic [7:0]               status;

  assign wr_acc  = cpu_cs & cpu_we;
  assign rd_acc  = cpu_cs & ~cpu_we;
  assign push    = wr_acc & (cpu_rs == REG_DATA) & ~full;
  assign ovf_set = wr_acc & (cpu_rs == REG_DATA) & full;
  assign stat_rd = rd_acc & (cpu_rs == REG_STATUS);
  assign pop     = vram_gnt & ~empty;
  assign vram_we = (state == ST_WRITE);
  assign busy    = ~empty | vram_we;

  always_comb begin
    status            = '0;
    status[STAT_FULL]  = full;
    status[STAT_EMPTY] = empty;
    status[STAT_BUSY]  = busy;
    status[STAT_OVF]   = overflow;
  end

  vram_wr_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({ptr, cpu_din}),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= '0;
      overflow <= 1'b0;
      cpu_dout <= '0;
    end else begin
      if (wr_acc) begin
        unique case (cpu_rs)
          REG_ADDR_LO: ptr[7:0]  <= cpu_din[7:0];
          REG_ADDR_HI: ptr[15:8] <= cpu_din[7:0];
          REG_DATA:    if (!full) ptr <= ptr + 1'b1;
          default:     ;
        endcase
      end
      if (rd_acc) begin
        unique case (cpu_rs)
          REG_ADDR_LO: cpu_dout <= DATA_W'(ptr[7:0]);
          REG_ADDR_HI: cpu_dout <= DATA_W'(ptr[15:8]);
          REG_DATA:    cpu_dout <= '0;
          default:     cpu_dout <= DATA_W'(status);
        endcase
      end
      if (ovf_set)      overflow <= 1'b1;
      else if (stat_rd) overflow <= 1'b0;
    end
  end

  // One pop per granted cycle; vram_we is the registered WRITE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      vram_addr  <= '0;
      vram_wdata <= '0;
    end else begin
      state <= pop ? ST_WRITE : ST_IDLE;
      if (pop) begin
        vram_addr  <= head[ADDR_W+DATA_W-1:DATA_W];
        vram_wdata <= head[DATA_W-1:0];
      end
    end
  end

`ifdef VRAM_WRITER_IRQ_EN
  logic drained;

  assign drained = pop & ~push & (count == CW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   irq <= 1'b0;
    else if (drained || ovf_set) irq <= 1'b1;
    else if (stat_rd)            irq <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_vram_writer.sv
// Bench for vram_writer: directed tables, corner sequences and random
// traffic checked against a queue-based reference model.
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs;
  logic        cpu_we;
  logic [1:0]  cpu_rs;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        vram_gnt;
  logic [15:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
`ifdef VRAM_WRITER_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  vram_writer dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_cs     (cpu_cs),
    .cpu_we     (cpu_we),
    .cpu_rs     (cpu_rs),
    .cpu_din    (cpu_din),
    .cpu_dout   (cpu_dout),
    .vram_gnt   (vram_gnt),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
`ifdef VRAM_WRITER_IRQ_EN
    .irq        (irq),
`endif
    .vram_we    (vram_we)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: queued writes, pointer, sticky flags, output images.
  logic [23:0] mq[$];
  logic [15:0] mptr;
  logic        movf;
  logic        mirq;
  logic        mwe;
  logic [15:0] maddr;
  logic [7:0]  mwd;
  logic [7:0]  mdout;

  function automatic void model_reset();
    mq.delete();
    mptr  = 16'h0;
    movf  = 1'b0;
    mirq  = 1'b0;
    mwe   = 1'b0;
    maddr = 16'h0;
    mwd   = 8'h0;
    mdout = 8'h0;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input string name);
    check(name, {24'h0, vram_we, 7'h0, vram_addr, vram_wdata, cpu_dout},
          {24'h0, mwe, 7'h0, maddr, mwd, mdout});
`ifdef VRAM_WRITER_IRQ_EN
    check({name, "_irq"}, {63'h0, irq}, {63'h0, mirq});
`endif
  endtask

  task automatic cyc(input logic cs, input logic we, input logic [1:0] rs,
                     input logic [7:0] din, input logic gnt);
    int          sz;
    bit          mfull, mempty, pop, push, ovf_set, irq_set, srd;
    logic [23:0] head;
    logic [7:0]  st;
    cpu_cs = cs; cpu_we = we; cpu_rs = rs; cpu_din = din; vram_gnt = gnt;
    sz      = mq.size();
    mfull   = (sz == 8);
    mempty  = (sz == 0);
    st      = {4'h0, movf, (!mempty || mwe), mempty, mfull};
    pop     = gnt && !mempty;
    head    = pop ? mq[0] : 24'h0;
    push    = cs && we && rs == 2'd2 && !mfull;
    ovf_set = cs && we && rs == 2'd2 && mfull;
    srd     = cs && !we && rs == 2'd3;
    irq_set = (pop && sz == 1 && !push) || ovf_set;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({mptr, din});
      mptr = mptr + 16'h1;
    end
    if (cs && we && rs == 2'd0) mptr[7:0]  = din;
    if (cs && we && rs == 2'd1) mptr[15:8] = din;
    if (cs && !we) begin
      case (rs)
        2'd0:    mdout = mptr[7:0];
        2'd1:    mdout = mptr[15:8];
        2'd2:    mdout = 8'h00;
        default: mdout = st;
      endcase
    end
    if (ovf_set)  movf = 1'b1;
    else if (srd) movf = 1'b0;
    if (irq_set)  mirq = 1'b1;
    else if (srd) mirq = 1'b0;
    mwe = pop;
    if (pop) {maddr, mwd} = head;
    @(posedge clk);
    #1;
    check_outputs("cycle");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_cs = 1'b0; cpu_we = 1'b0; cpu_rs = 2'd0; cpu_din = 8'h0;
    vram_gnt = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  rs;
    logic [7:0]  din;
    logic        e_we;
    logic [15:0] e_addr;
    logic [7:0]  e_wd;
    logic [7:0]  e_dout;
  } vec_t;

  vec_t t1[7];

  initial begin
    t1[0] = '{1'b1, 2'd1, 8'h12, 1'b0, 16'h0000, 8'h00, 8'h00};
    t1[1] = '{1'b1, 2'd0, 8'h34, 1'b0, 16'h0000, 8'h00, 8'h00};
    t1[2] = '{1'b1, 2'd2, 8'hA5, 1'b0, 16'h0000, 8'h00, 8'h00};
    t1[3] = '{1'b1, 2'd2, 8'h5A, 1'b1, 16'h1234, 8'hA5, 8'h00};
    t1[4] = '{1'b0, 2'd0, 8'h00, 1'b1, 16'h1235, 8'h5A, 8'h36};
    t1[5] = '{1'b0, 2'd1, 8'h00, 1'b0, 16'h1235, 8'h5A, 8'h12};
    t1[6] = '{1'b0, 2'd3, 8'h00, 1'b0, 16'h1235, 8'h5A, 8'h02};

    do_reset();
    check_outputs("reset_state");

    // Pointer load, two pushes, back-to-back drain with gnt held high.
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, t1[i].we, t1[i].rs, t1[i].din, 1'b1);
      check($sformatf("table1_%0d", i),
            {31'h0, vram_we, vram_addr, vram_wdata, cpu_dout},
            {31'h0, t1[i].e_we, t1[i].e_addr, t1[i].e_wd, t1[i].e_dout});
    end

    // Overflow: nine pushes into an eight-deep FIFO with no grant.
    cyc(1'b1, 1'b1, 2'd1, 8'h01, 1'b0);
    cyc(1'b1, 1'b1, 2'd0, 8'h00, 1'b0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 2'd2, 8'h30 + 8'(i), 1'b0);
    cyc(1'b1, 1'b0, 2'd3, 8'h00, 1'b0);
    check("ovf_status", {56'h0, cpu_dout}, {56'h0, 8'h0D});
    cyc(1'b1, 1'b0, 2'd3, 8'h00, 1'b0);
    check("ovf_cleared", {56'h0, cpu_dout}, {56'h0, 8'h05});
    cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
    check("ovf_ptr_lo", {56'h0, cpu_dout}, {56'h0, 8'h08});
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);

    // Pointer wrap from 0xFFFF to 0x0000.
    cyc(1'b1, 1'b1, 2'd1, 8'hFF, 1'b1);
    cyc(1'b1, 1'b1, 2'd0, 8'hFF, 1'b1);
    cyc(1'b1, 1'b1, 2'd2, 8'h11, 1'b1);
    cyc(1'b1, 1'b1, 2'd2, 8'h22, 1'b1);
    check("wrap_first", {40'h0, vram_addr, vram_wdata}, {40'h0, 16'hFFFF, 8'h11});
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    check("wrap_second", {40'h0, vram_addr, vram_wdata}, {40'h0, 16'h0000, 8'h22});

    // Grant toggling with three bytes queued.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 2'd2, 8'h70 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    check("gnt_gap", {63'h0, vram_we}, 64'h0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);

    // Asynchronous reset in the middle of a drain.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 2'd2, 8'h90 + 8'(i), 1'b0);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, 2'd3, 8'h00, 1'b1);
    check("post_reset_status", {56'h0, cpu_dout}, {56'h0, 8'h02});
    cyc(1'b1, 1'b0, 2'd1, 8'h00, 1'b1);
    check("post_reset_ptr", {56'h0, cpu_dout}, 64'h0);

`ifdef VRAM_WRITER_IRQ_EN
    cyc(1'b1, 1'b1, 2'd2, 8'hC1, 1'b0);
    cyc(1'b1, 1'b1, 2'd2, 8'hC2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    check("irq_set", {63'h0, irq}, 64'h1);
    cyc(1'b1, 1'b0, 2'd3, 8'h00, 1'b0);
    check("irq_clear", {63'h0, irq}, 64'h0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 8,
          2'($urandom_range(0, 3)), 8'($urandom),
          $urandom_range(0, 9) < 4);
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
    check("final_drained", {63'h0, vram_we}, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
